alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the next CPU generation; replaces the purely combinational ALU in the execute stage.
- Adds registered outputs, a valid/ready handshake, SRL/SRA, an overflow flag, and iterative unsigned multiply/divide producing a HI/LO pair.
- Sits between the register-file read operands and the writeback/HI-LO registers; the control unit stalls the pipeline while in_ready is low.

Parameters:
- WIDTH, 32, operand/result width; must be >= 4.
- SHW, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- opcode  in  4  operation select; see Behaviour.
- rega  in  WIDTH  operand A; the shift amount for shift ops.
- regb  in  WIDTH  operand B; the value shifted for shift ops.
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  one-cycle pulse when result_lo/result_hi are valid.
- result_lo  out  WIDTH  primary result; product low half; quotient.
- result_hi  out  WIDTH  product high half; remainder; 0 for other ops.
- zero  out  1  result_lo == 0, registered with the result.
- sign  out  1  result_lo[WIDTH-1].
- ovf  out  1  signed overflow; ADD/SUB only, else 0.
- illegal  out  1  unused opcode accepted; registered with the result.

Behaviour:
- Opcodes:
  - 0000 ADD a+b; 0001 SUB a-b.
  - 0010 SLL b<<a[SHW-1:0]; 1000 SRL b>>a[SHW-1:0]; 1001 SRA arithmetic shift of b by a[SHW-1:0].
  - 0011 OR; 0100 AND; 0111 XNOR.
  - 0101 SLTU unsigned a<b; 0110 SLT signed a<b; both return 1 or 0.
  - 1010 MULU; 1011 DIVU.
  - All other opcodes: result 0, illegal=1.
- Shift amount uses only the low SHW bits of rega; upper bits are ignored.
- States are IDLE, BUSY, DONE.
- in_ready = (state != BUSY).
- A request is accepted when in_valid && in_ready; operands and opcode are latched on acceptance.
- Single-cycle ops: accept -> DONE next cycle. out_valid=1 with the results in that cycle (latency 1).
- A new request accepted in DONE is processed normally, so back-to-back single-cycle ops run at 1 per cycle.
- MULU/DIVU: accept -> BUSY for exactly WIDTH cycles (one shift-add or restoring-subtract step each) -> DONE. out_valid rises WIDTH+1 cycles after acceptance.
- DONE with no new accept -> IDLE.
- out_valid is high only in DONE.
- result_lo, result_hi and all flags hold their values until the next DONE.
- MULU: {result_hi,result_lo} = a*b (2*WIDTH-bit product).
- DIVU: result_lo = a/b, result_hi = a%b.
- DIVU with b==0: result_lo = all ones, result_hi = a; no other flag is set.
- ovf:
  - ADD: a[MSB]==b[MSB] && sum[MSB]!=a[MSB].
  - SUB: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB].
  - Wraps modulo 2^WIDTH; no trap.
- flush:
  - Forces state to IDLE next cycle.
  - Suppresses out_valid, including a DONE that would otherwise occur that cycle.
  - Leaves result registers unchanged.
  - flush has priority over a simultaneous accept; the request is dropped.
- Reset:
  - state IDLE; out_valid=0; result_lo, result_hi=0; zero=1; sign, ovf, illegal=0; iteration counter 0.
  - in_ready=1 from the first cycle after Reset deasserts.
  - Reset mid-BUSY discards the operation.
- in_valid while BUSY is ignored; the requester must hold the request until in_ready.

Optional Feature:
- Macro ALU_MC_SIGNED_MULDIV_EN.
- Defined: opcode 1100 MUL (signed product) and 1101 DIV (signed, truncating toward zero; remainder takes the sign of the dividend).
  - Implemented by sign-correcting the unsigned iterations; same WIDTH+1 latency.
  - DIV by 0: result_lo = all ones, result_hi = a.
  - DIV of MIN by -1: result_lo = MIN, result_hi = 0, ovf=1.
- Undefined: 1100 and 1101 behave as illegal opcodes (result 0, illegal=1, latency 1).

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 -> next cycle out_valid=1, result_lo=0x80000000, ovf=1, sign=1, zero=0.
- Back-to-back SUB 5-5, then SLT 0xFFFFFFFF vs 1, then SLTU same operands -> three consecutive out_valid cycles: result_lo 0 (zero=1), then 1, then 0.
- SRA a=4 b=0x80000010 -> 0xF8000001.
  - Then SLL a=0x21 b=1 -> 0x2 (only the low 5 bits of a are used).
- MULU a=0xFFFFFFFF b=2 -> in_ready low 32 cycles, out_valid at cycle 33 with result_hi=0x1, result_lo=0xFFFFFFFE.
- DIVU a=100 b=7 -> result_lo=14, result_hi=2.
  - DIVU a=9 b=0 -> result_lo=0xFFFFFFFF, result_hi=9.
- Start DIVU, assert flush at BUSY cycle 10 -> no out_valid, in_ready=1 next cycle, results unchanged.
  - Repeat with Reset instead of flush -> all outputs at reset values.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the execute stage.
// Single-cycle ops (add/sub/shift/logic/compare) return one cycle after
// acceptance; MULU/DIVU iterate one bit per cycle for WIDTH cycles.
// Optional macro ALU_MC_SIGNED_MULDIV_EN adds signed MUL (1100) and DIV (1101).
// Ports:
//   CLK, Reset            clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready low only while BUSY)
//   opcode, rega, regb    operation select and operands (rega = shift amount)
//   flush                 abort any in-flight operation
//   out_valid             one-cycle pulse when results are updated
//   result_lo, result_hi  primary result / product halves / quotient,remainder
//   zero, sign, ovf, illegal  flags registered with the result
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] rega,
    input  logic [WIDTH-1:0] regb,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             sign,
    output logic             ovf,
    output logic             illegal
);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_XNOR = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MULU = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
`ifdef ALU_MC_SIGNED_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIV  = 4'b1101;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           r_state, w_next_state;
    logic             r_is_div;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_b;
    logic [WIDTH-1:0] r_res_lo, r_res_hi;
    logic             r_zero, r_sign, r_ovf, r_illegal;

    logic             w_accept, w_is_md, w_last;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_op_a, w_op_b;
    logic [WIDTH-1:0] w_sum, w_diff, w_sc_lo;
    logic             w_sc_ovf, w_sc_ill;
    logic [WIDTH:0]   w_mul_sum, w_rem_sh, w_rem_diff;
    logic [WIDTH-1:0] w_step_hi, w_step_lo, w_fin_hi, w_fin_lo;
    logic             w_fin_ovf;

`ifdef ALU_MC_SIGNED_MULDIV_EN
    logic               w_a_neg, w_b_neg;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic               r_sgn, r_neg_q, r_neg_r, r_bz, r_minovf;
    logic [WIDTH-1:0]   r_a;
`endif

    assign w_accept  = in_valid && in_ready && !flush;
    assign w_last    = (r_cnt == SHW'(WIDTH - 1));
    assign result_lo = r_res_lo;
    assign result_hi = r_res_hi;
    assign zero      = r_zero;
    assign sign      = r_sign;
    assign ovf       = r_ovf;
    assign illegal   = r_illegal;

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic; flush overrides everything, including a pending accept
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) w_next_state = w_is_md ? BUSY : DONE;
                else          w_next_state = IDLE;
            end
            BUSY:    if (w_last) w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
        if (flush) w_next_state = IDLE;
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = (r_state != BUSY);
        out_valid = (r_state == DONE);
    end

    // Multi-cycle op decode and operand preparation (magnitudes for signed ops)
    always_comb begin
        w_is_md = (opcode == OP_MULU) || (opcode == OP_DIVU);
        w_op_a  = rega;
        w_op_b  = regb;
`ifdef ALU_MC_SIGNED_MULDIV_EN
        if ((opcode == OP_MUL) || (opcode == OP_DIV)) w_is_md = 1'b1;
        w_a_neg = opcode[2] && rega[MSB];
        w_b_neg = opcode[2] && regb[MSB];
        if (w_a_neg) w_op_a = -rega;
        if (w_b_neg) w_op_b = -regb;
`endif
    end

    // Single-cycle result
    always_comb begin
        w_sh     = rega[SHW-1:0];
        w_sum    = rega + regb;
        w_diff   = rega - regb;
        w_sc_lo  = '0;
        w_sc_ovf = 1'b0;
        w_sc_ill = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_sc_lo  = w_sum;
                w_sc_ovf = (rega[MSB] == regb[MSB]) && (w_sum[MSB] != rega[MSB]);
            end
            OP_SUB: begin
                w_sc_lo  = w_diff;
                w_sc_ovf = (rega[MSB] != regb[MSB]) && (w_diff[MSB] != rega[MSB]);
            end
            OP_SLL:  w_sc_lo = regb << w_sh;
            OP_SRL:  w_sc_lo = regb >> w_sh;
            OP_SRA:  w_sc_lo = WIDTH'($signed(regb) >>> w_sh);
            OP_OR:   w_sc_lo = rega | regb;
            OP_AND:  w_sc_lo = rega & regb;
            OP_XNOR: w_sc_lo = ~(rega ^ regb);
            OP_SLTU: w_sc_lo = WIDTH'(rega < regb);
            OP_SLT:  w_sc_lo = WIDTH'($signed(rega) < $signed(regb));
            default: w_sc_ill = !w_is_md;
        endcase
    end

    // One iteration: shift-add multiply (hi accumulates, lo shifts out the
    // multiplier) or restoring divide (hi = remainder, lo = dividend/quotient)
    always_comb begin
        w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_rem_sh   = {r_hi, r_lo[MSB]};
        w_rem_diff = w_rem_sh - {1'b0, r_b};
        if (r_is_div) begin
            if (!w_rem_diff[WIDTH]) begin
                w_step_hi = w_rem_diff[WIDTH-1:0];
                w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_rem_sh[WIDTH-1:0];
                w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Final result; unsigned divide by zero naturally yields all-ones / a
    always_comb begin
        w_fin_hi  = w_step_hi;
        w_fin_lo  = w_step_lo;
        w_fin_ovf = 1'b0;
`ifdef ALU_MC_SIGNED_MULDIV_EN
        w_prod_neg = -{w_step_hi, w_step_lo};
        if (r_sgn) begin
            if (!r_is_div) begin
                if (r_neg_q) {w_fin_hi, w_fin_lo} = w_prod_neg;
            end else if (r_bz) begin
                w_fin_lo = '1;
                w_fin_hi = r_a;
            end else begin
                if (r_neg_q) w_fin_lo = -w_step_lo;
                if (r_neg_r) w_fin_hi = -w_step_hi;
                w_fin_ovf = r_minovf;
            end
        end
`endif
    end

    // Datapath and result registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_res_lo  <= '0;
            r_res_hi  <= '0;
            r_zero    <= 1'b1;
            r_sign    <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_MC_SIGNED_MULDIV_EN
            r_sgn     <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_bz      <= 1'b0;
            r_minovf  <= 1'b0;
            r_a       <= '0;
`endif
        end else begin
            if (w_accept && w_is_md) begin
                r_cnt    <= '0;
                r_is_div <= opcode[0];
                r_hi     <= '0;
                r_lo     <= w_op_a;
                r_b      <= w_op_b;
`ifdef ALU_MC_SIGNED_MULDIV_EN
                r_sgn    <= opcode[2];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_bz     <= (regb == '0);
                r_minovf <= (rega == {1'b1, {MSB{1'b0}}}) && (regb == '1);
                r_a      <= rega;
`endif
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + SHW'(1);
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
            end

            // Results only move when entering DONE; flush leaves them untouched
            if (w_accept && !w_is_md) begin
                r_res_lo  <= w_sc_lo;
                r_res_hi  <= '0;
                r_zero    <= (w_sc_lo == '0);
                r_sign    <= w_sc_lo[MSB];
                r_ovf     <= w_sc_ovf;
                r_illegal <= w_sc_ill;
            end else if ((r_state == BUSY) && w_last && !flush) begin
                r_res_lo  <= w_fin_lo;
                r_res_hi  <= w_fin_hi;
                r_zero    <= (w_fin_lo == '0);
                r_sign    <= w_fin_lo[MSB];
                r_ovf     <= w_fin_ovf;
                r_illegal <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (default build, WIDTH=32): an arithmetic reference model
// with a per-cycle compare, plus directed vectors with literal expectations.
module tb_alu_mc;
    logic        CLK = 1'b0;
    logic        Reset, in_valid, flush;
    logic [3:0]  opcode;
    logic [31:0] rega, regb;
    logic        in_ready, out_valid, zero, sign, ovf, illegal;
    logic [31:0] result_lo, result_hi;

    alu_mc #(.WIDTH(32), .SHW(5)) dut (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rega(rega), .regb(regb), .flush(flush),
        .out_valid(out_valid), .result_lo(result_lo), .result_hi(result_hi),
        .zero(zero), .sign(sign), .ovf(ovf), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Reference model: results from plain arithmetic
    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ovf;
        logic        ill;
        logic        multi;
    } res_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      sa, sb, full;
        logic [63:0] p;
        r.lo = '0; r.hi = '0; r.ovf = 1'b0; r.ill = 1'b0; r.multi = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: begin full = sa + sb; r.lo = 32'(full); r.ovf = (full > SMAX) || (full < SMIN); end
            4'd1: begin full = sa - sb; r.lo = 32'(full); r.ovf = (full > SMAX) || (full < SMIN); end
            4'd2: r.lo = b << (a % 32);
            4'd3: r.lo = a | b;
            4'd4: r.lo = a & b;
            4'd5: r.lo = (a < b) ? 32'd1 : 32'd0;
            4'd6: r.lo = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: r.lo = ~(a ^ b);
            4'd8: r.lo = b >> (a % 32);
            4'd9: r.lo = 32'(sb >>> (a % 32));
            4'd10: begin
                p = {32'd0, a} * {32'd0, b};
                r.lo = p[31:0]; r.hi = p[63:32]; r.multi = 1'b1;
            end
            4'd11: begin
                r.multi = 1'b1;
                if (b == 0) begin r.lo = '1; r.hi = a; end
                else begin r.lo = a / b; r.hi = a % b; end
            end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Model state: cycles left busy, pending result, held outputs
    logic        m_init = 1'b0;
    int          m_busy = 0;
    logic        m_valid = 1'b0;
    res_t        m_pend;
    logic [31:0] m_lo = '0, m_hi = '0;
    logic        m_zero = 1'b1, m_sign = 1'b0, m_ovf = 1'b0, m_ill = 1'b0;

    task automatic apply(input res_t r);
        m_lo = r.lo; m_hi = r.hi; m_zero = (r.lo == 0);
        m_sign = r.lo[31]; m_ovf = r.ovf; m_ill = r.ill;
    endtask

    task automatic model_step();
        res_t r;
        logic nv;
        if (Reset) begin
            m_init = 1'b1; m_busy = 0; m_valid = 1'b0;
            m_lo = '0; m_hi = '0; m_zero = 1'b1; m_sign = 1'b0; m_ovf = 1'b0; m_ill = 1'b0;
        end else begin
            nv = 1'b0;
            if (flush) m_busy = 0;
            else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin nv = 1'b1; apply(m_pend); end
            end else if (in_valid) begin
                r = model(opcode, rega, regb);
                if (r.multi) begin m_busy = 32; m_pend = r; end
                else begin nv = 1'b1; apply(r); end
            end
            m_valid = nv;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge CLK);
        if (m_init) begin
            chk("cmp_ready", in_ready, (m_busy == 0));
            chk("cmp_valid", out_valid, m_valid);
            chk("cmp_lo", result_lo, m_lo);
            chk("cmp_hi", result_hi, m_hi);
            chk("cmp_zero", zero, m_zero);
            chk("cmp_sign", sign, m_sign);
            chk("cmp_ovf", ovf, m_ovf);
            chk("cmp_ill", illegal, m_ill);
        end
    end

    // Present a request at the current negedge; return one negedge after acceptance
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; opcode = op; rega = a; regb = b;
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge CLK);
        chk("send_ready", in_ready, 1'b1);
        @(negedge CLK);
    endtask

    task automatic idle();
        in_valid = 1'b0; opcode = 4'd0; rega = '0; regb = '0;
    endtask

    task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi);
        int n, lowcnt;
        send(op, a, b);
        idle();
        n = 1; lowcnt = 0;
        while (!out_valid && n < 100) begin
            if (!in_ready) lowcnt++;
            @(negedge CLK);
            n++;
        end
        chk({name, "_lat"}, n, 33);
        chk({name, "_rdy_low"}, lowcnt, 32);
        chk({name, "_lo"}, result_lo, elo);
        chk({name, "_hi"}, result_hi, ehi);
        @(negedge CLK);
    endtask

    logic [3:0]  t_op [12] = '{4'd1, 4'd0, 4'd3, 4'd4, 4'd7, 4'd8, 4'd2, 4'd15,
                               4'd9, 4'd0, 4'd10, 4'd11};
    logic [31:0] t_a  [12] = '{32'h80000000, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hFF00FF00,
                               32'h12345678, 32'hFFFFFFE4, 32'd31, 32'h1, 32'd0,
                               32'h80000000, 32'h12345678, 32'hFFFFFFFF};
    logic [31:0] t_b  [12] = '{32'h1, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0FF00FF0,
                               32'h87654321, 32'h80000010, 32'h3, 32'h2, 32'h80000001,
                               32'h80000000, 32'h9ABCDEF0, 32'd10};

    initial begin
        Reset = 1'b1; in_valid = 1'b0; flush = 1'b0; opcode = '0; rega = '0; regb = '0;
        repeat (2) @(negedge CLK);
        chk("rst_lo", result_lo, 32'h0);
        chk("rst_hi", result_hi, 32'h0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        Reset = 1'b0;
        @(negedge CLK);
        chk("rst_ready", in_ready, 1'b1);

        send(4'd0, 32'h7FFFFFFF, 32'h1);
        chk("add_valid", out_valid, 1'b1);
        chk("add_lo", result_lo, 32'h80000000);
        chk("add_ovf", ovf, 1'b1);
        chk("add_sign", sign, 1'b1);
        chk("add_zero", zero, 1'b0);

        send(4'd1, 32'd5, 32'd5);
        chk("b2b_sub_valid", out_valid, 1'b1);
        chk("b2b_sub_lo", result_lo, 32'h0);
        chk("b2b_sub_zero", zero, 1'b1);
        send(4'd6, 32'hFFFFFFFF, 32'h1);
        chk("b2b_slt_valid", out_valid, 1'b1);
        chk("b2b_slt_lo", result_lo, 32'h1);
        send(4'd5, 32'hFFFFFFFF, 32'h1);
        chk("b2b_sltu_valid", out_valid, 1'b1);
        chk("b2b_sltu_lo", result_lo, 32'h0);

        send(4'd9, 32'd4, 32'h80000010);
        chk("sra_lo", result_lo, 32'hF8000001);
        send(4'd2, 32'h21, 32'h1);
        chk("sll_lo", result_lo, 32'h2);
        send(4'd1, 32'h80000000, 32'h1);
        chk("sub_ovf_lo", result_lo, 32'h7FFFFFFF);
        chk("sub_ovf", ovf, 1'b1);
        send(4'd12, 32'h5, 32'h6);
        chk("ill_valid", out_valid, 1'b1);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_lo", result_lo, 32'h0);
        idle();
        @(negedge CLK);

        run_md("mulu", 4'd10, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1);
        run_md("divu", 4'd11, 32'd100, 32'd7, 32'd14, 32'd2);
        run_md("div0", 4'd11, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9);

        // Flush at BUSY cycle 10
        send(4'd11, 32'd1000, 32'd3);
        idle();
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        chk("flush_ready", in_ready, 1'b1);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_lo", result_lo, 32'hFFFFFFFF);
        chk("flush_hi", result_hi, 32'd9);
        repeat (40) @(negedge CLK);

        // Flush with a simultaneous request drops the request
        in_valid = 1'b1; opcode = 4'd0; rega = 32'd1; regb = 32'd1; flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        idle();
        chk("flush_drop_valid", out_valid, 1'b0);
        chk("flush_drop_lo", result_lo, 32'hFFFFFFFF);
        @(negedge CLK);

        // Reset at BUSY cycle 10
        send(4'd11, 32'd50, 32'd5);
        idle();
        repeat (9) @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        chk("rst2_lo", result_lo, 32'h0);
        chk("rst2_hi", result_hi, 32'h0);
        chk("rst2_zero", zero, 1'b1);
        chk("rst2_valid", out_valid, 1'b0);
        chk("rst2_ready", in_ready, 1'b1);
        repeat (40) @(negedge CLK);

        // Mixed stream, model-checked, including MULU accepted straight from DONE
        for (int i = 0; i < 12; i++) send(t_op[i], t_a[i], t_b[i]);
        idle();
        repeat (40) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
